// File: rtl/rd_data_return_mux_pkg.sv
// Shared types and helpers for the read-data return mux.
// Vector helpers take a MAX_SLV-wide argument; callers zero-extend narrower selects.
package rd_mux_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int         MAX_SLV      = 32;
    localparam logic [7:0] ERR_DATA_DEF = 8'hEE;

    function automatic logic is_onehot(input logic [MAX_SLV-1:0] v);
        return (v != '0) && ((v & (v - MAX_SLV'(1))) == '0);
    endfunction

    // Clearing the lowest set bit leaves something only if two or more bits were set.
    function automatic logic popcount_gt1(input logic [MAX_SLV-1:0] v);
        return (v & (v - MAX_SLV'(1))) != '0;
    endfunction

endpackage

// File: rtl/rd_data_return_mux_if.sv
// Request/slave-return/response bundle between decoder, slaves, mux and bus master.
// master drives request and slave returns; slave modport is the mux's view.
interface rd_data_return_mux_if #(
    parameter int NUM_SLV = 4,
    parameter int DATA_W  = 8
);
    logic                      i_rd_req;
    logic [NUM_SLV-1:0]        i_sel;
    logic [NUM_SLV*DATA_W-1:0] i_slv_data;
    logic [NUM_SLV-1:0]        i_slv_valid;
    logic [DATA_W-1:0]         o_data;
    logic                      o_valid;
    logic                      o_err;
    logic                      o_busy;
    logic                      o_req_drop;
    logic                      o_collision;

    modport master (
        output i_rd_req, i_sel, i_slv_data, i_slv_valid,
        input  o_data, o_valid, o_err, o_busy, o_req_drop, o_collision
    );

    modport slave (
        input  i_rd_req, i_sel, i_slv_data, i_slv_valid,
        output o_data, o_valid, o_err, o_busy, o_req_drop, o_collision
    );
endinterface

// File: rtl/rd_data_return_mux_slice_sel.sv
// Combinational mask-and-OR of NUM_SLV data slices by a one-hot select; no priority.
// Latency 0; no flow control.
module rd_onehot_slice_sel #(
    parameter int NUM_SLV = 4,
    parameter int DATA_W  = 8
) (
    input  logic [NUM_SLV-1:0]        sel_i,
    input  logic [NUM_SLV*DATA_W-1:0] data_i,
    output logic [DATA_W-1:0]         data_o
);
    always_comb begin
        data_o = '0;
        for (int k = 0; k < NUM_SLV; k++) begin
            data_o = data_o | (data_i[k*DATA_W +: DATA_W] & {DATA_W{sel_i[k]}});
        end
    end
endmodule

// File: rtl/rd_data_return_mux.sv
// Read-data return mux: latch one-hot select, wait for that slave's valid or time out, register response.
// Latency: valid at t -> o_valid at t+1; requests while busy are dropped. Optional: RD_COLLISION_DET_EN.
module rd_data_return_mux
    import rd_mux_pkg::*;
#(
    parameter int                NUM_SLV     = 4,
    parameter int                DATA_W      = 8,
    parameter int                TIMEOUT_CYC = 8,
    parameter logic [DATA_W-1:0] ERR_DATA    = DATA_W'(ERR_DATA_DEF)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    rd_data_return_mux_if.slave    bus
);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_SLV-1:0] sel_q, sel_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    logic               drop_q, drop_d;
    logic [DATA_W-1:0]  slv_word;
    logic               sel_hit;

    rd_onehot_slice_sel #(
        .NUM_SLV (NUM_SLV),
        .DATA_W  (DATA_W)
    ) u_slice_sel (
        .sel_i  (sel_q),
        .data_i (bus.i_slv_data),
        .data_o (slv_word)
    );

    assign sel_hit = |(sel_q & bus.i_slv_valid);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        drop_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.i_rd_req) begin
                    if (is_onehot(MAX_SLV'(bus.i_sel))) begin
                        sel_d   = bus.i_sel;
                        cnt_d   = CNT_W'(TIMEOUT_CYC);
                        state_d = WAIT;
                    end else begin
                        data_d  = ERR_DATA;
                        valid_d = 1'b1;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                drop_d = bus.i_rd_req;
                // A valid on the last counted cycle is checked first so real data beats the timeout.
                if (sel_hit) begin
                    data_d  = slv_word;
                    valid_d = 1'b1;
                    state_d = RESP;
                end else if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    data_d  = ERR_DATA;
                    valid_d = 1'b1;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                drop_d  = bus.i_rd_req;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            drop_q  <= drop_d;
        end
    end

`ifdef RD_COLLISION_DET_EN
    logic coll_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            coll_q <= 1'b0;
        end else begin
            coll_q <= (state_q == WAIT) && popcount_gt1(MAX_SLV'(bus.i_slv_valid));
        end
    end

    assign bus.o_collision = coll_q;
`else
    assign bus.o_collision = 1'b0;
`endif

    assign bus.o_data     = data_q;
    assign bus.o_valid    = valid_q;
    assign bus.o_err      = err_q;
    assign bus.o_busy     = (state_q != IDLE);
    assign bus.o_req_drop = drop_q;

endmodule

// File: tb/tb_rd_data_return_mux.sv
// Directed bench for rd_data_return_mux; a negedge monitor pops expected responses/pulses from queues.
module tb_rd_data_return_mux;
    import rd_mux_pkg::*;

    typedef struct {
        int         cyc;
        logic       err;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t expq[$];
    int   dropq[$];
    int   collq[$];

    rd_data_return_mux_if #(.NUM_SLV(4), .DATA_W(8)) bus ();

    rd_data_return_mux #(
        .NUM_SLV     (4),
        .DATA_W      (8),
        .TIMEOUT_CYC (8),
        .ERR_DATA    (8'hEE)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_resp(input logic err, input logic [7:0] data);
        exp_t e;
        e.cyc  = cyc + 1;
        e.err  = err;
        e.data = data;
        expq.push_back(e);
    endtask

    task automatic request(input logic [3:0] sel);
        bus.i_rd_req = 1'b1;
        bus.i_sel    = sel;
        step();
        bus.i_rd_req = 1'b0;
        bus.i_sel    = 4'b0000;
    endtask

    task automatic slv_drive(input logic [3:0] vld, input int k, input logic [7:0] d);
        bus.i_slv_valid = vld;
        bus.i_slv_data[k*8 +: 8] = d;
    endtask

    // Monitor: every output pulse must match the head of its queue, at the expected cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.o_valid) begin
                if (expq.size() == 0) begin
                    chk("unexpected_o_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("resp_cycle", cyc, e.cyc);
                    chk("resp_err", bus.o_err, e.err);
                    chk("resp_data", bus.o_data, e.data);
                end
            end
            if (bus.o_req_drop) begin
                if (dropq.size() == 0) chk("unexpected_req_drop", 1, 0);
                else chk("req_drop_cycle", cyc, dropq.pop_front());
            end
            if (bus.o_collision) begin
                if (collq.size() == 0) chk("unexpected_collision", 1, 0);
                else chk("collision_cycle", cyc, collq.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        bus.i_rd_req    = 1'b0;
        bus.i_sel       = 4'b0000;
        bus.i_slv_data  = '0;
        bus.i_slv_valid = 4'b0000;
        #1 rst = 1'b1;
        #2;
        chk("rst_o_data", bus.o_data, 0);
        chk("rst_o_valid", bus.o_valid, 0);
        chk("rst_o_err", bus.o_err, 0);
        chk("rst_o_busy", bus.o_busy, 0);
        chk("rst_o_req_drop", bus.o_req_drop, 0);
        chk("rst_o_collision", bus.o_collision, 0);
        step();
        rst = 1'b0;
        step();

        // Selected slave 2 answers three cycles after the request.
        request(4'b0100);
        chk("t1_busy_wait", bus.o_busy, 1);
        step();
        step();
        slv_drive(4'b0100, 2, 8'hA5);
        push_resp(1'b0, 8'hA5);
        step();
        slv_drive(4'b0000, 2, 8'h00);
        chk("t1_busy_resp", bus.o_busy, 1);
        step();
        chk("t1_busy_idle", bus.o_busy, 0);
        chk("t1_data_hold", bus.o_data, 8'hA5);
        step();

        // Timeout; a lone unselected valid along the way is ignored.
        request(4'b0100);
        for (int i = 1; i <= 8; i++) begin
            if (i == 3) slv_drive(4'b0001, 0, 8'h99);
            else slv_drive(4'b0000, 0, 8'h00);
            if (i == 8) push_resp(1'b1, 8'hEE);
            step();
        end
        slv_drive(4'b0000, 0, 8'h00);
        step();
        chk("t2_busy_idle", bus.o_busy, 0);

        // Valid on the final counted cycle wins over timeout.
        request(4'b0100);
        for (int i = 1; i <= 7; i++) step();
        slv_drive(4'b0100, 2, 8'h77);
        push_resp(1'b0, 8'h77);
        step();
        slv_drive(4'b0000, 2, 8'h00);
        step();

        // Multi-hot and zero selects respond with an error immediately.
        push_resp(1'b1, 8'hEE);
        request(4'b0110);
        chk("t3_busy_resp", bus.o_busy, 1);
        step();
        push_resp(1'b1, 8'hEE);
        request(4'b0000);
        step();
        chk("t3_busy_idle", bus.o_busy, 0);

        // Requests while busy are dropped; the outstanding one completes once.
        request(4'b0100);
        dropq.push_back(cyc + 1);
        request(4'b0001);
        step();
        slv_drive(4'b0101, 2, 8'hC3);
        bus.i_slv_data[7:0] = 8'h12;
        push_resp(1'b0, 8'hC3);
`ifdef RD_COLLISION_DET_EN
        collq.push_back(cyc + 1);
`endif
        step();
        slv_drive(4'b0000, 2, 8'h00);
        dropq.push_back(cyc + 1);
        request(4'b1000);
        chk("t4_busy_after_drop", bus.o_busy, 0);
        step();

        // Two valids in one WAIT cycle: data comes from the selected slave.
        request(4'b0100);
        bus.i_slv_valid = 4'b0110;
        bus.i_slv_data[15:8]  = 8'h3C;
        bus.i_slv_data[23:16] = 8'h5A;
        push_resp(1'b0, 8'h5A);
`ifdef RD_COLLISION_DET_EN
        collq.push_back(cyc + 1);
`endif
        step();
        slv_drive(4'b0000, 2, 8'h00);
        step();
        step();

        // Reset mid-WAIT aborts without a response.
        request(4'b0001);
        step();
        #1 rst = 1'b1;
        #1;
        chk("midrst_o_data", bus.o_data, 0);
        chk("midrst_o_valid", bus.o_valid, 0);
        chk("midrst_o_err", bus.o_err, 0);
        chk("midrst_o_busy", bus.o_busy, 0);
        chk("midrst_o_req_drop", bus.o_req_drop, 0);
        chk("midrst_o_collision", bus.o_collision, 0);
        rst = 1'b0;
        step();
        slv_drive(4'b0001, 0, 8'h11);
        step();
        slv_drive(4'b0000, 0, 8'h00);
        step();
        request(4'b0001);
        step();
        slv_drive(4'b0001, 0, 8'h11);
        push_resp(1'b0, 8'h11);
        step();
        slv_drive(4'b0000, 0, 8'h00);
        step();
        step();
        step();

        chk("resp_queue_drained", expq.size(), 0);
        chk("drop_queue_drained", dropq.size(), 0);
        chk("collision_queue_drained", collq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rd_data_return_mux.md
Name: rd_data_return_mux

Overview:
- Parametrised successor to the OR-combining read-data mux.
- Returns register read data from NUM_SLV peripheral slaves (PPS dividers, pulse generators, thunder interface, main memory) to the bus master.
- Instead of blindly ORing all slave buses, it captures a one-hot slave select at request time, waits for that slave's valid strobe, and delivers a registered response.
- Timeout/error reporting covers absent or misaddressed slaves; the block sits between the address decoder and the master read port.

Parameters:
- NUM_SLV, 4, number of slave channels (>=1).
- DATA_W, 8, read data width.
- TIMEOUT_CYC, 8, wait cycles before a timeout error (>=1).
- ERR_DATA, 8'hEE, data driven on error responses (DATA_W wide).

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_rd_req  in  1  single-cycle read request strobe.
- i_sel  in  NUM_SLV  one-hot slave select from the address decoder, sampled with i_rd_req.
- i_slv_data  in  NUM_SLV*DATA_W  concatenated slave read data; slave k occupies bits [k*DATA_W +: DATA_W].
- i_slv_valid  in  NUM_SLV  per-slave data-valid strobe.
- o_data  out  DATA_W  registered response data.
- o_valid  out  1  one-cycle response strobe.
- o_err  out  1  qualifies o_valid; high means an error response.
- o_busy  out  1  high while a request is outstanding.
- o_req_drop  out  1  one-cycle pulse when a request is ignored.
- o_collision  out  1  multi-valid flag; see Optional Feature.

Behaviour:
- Reset (async assert, sync release): state IDLE; o_data=0, o_valid=0, o_err=0, o_busy=0, o_req_drop=0, o_collision=0; sel register and counter cleared.
- Reset mid-operation aborts the transaction. No response is issued for the aborted request.
- States: IDLE, WAIT, RESP.
- IDLE, i_rd_req=1 with i_sel exactly one-hot:
  - latch i_sel;
  - load counter=TIMEOUT_CYC;
  - o_busy=1 from the next cycle;
  - go to WAIT.
- IDLE, i_rd_req=1 with i_sel zero or multi-hot:
  - go to RESP;
  - o_valid=1, o_err=1, o_data=ERR_DATA on the next cycle;
  - no WAIT phase.
- WAIT:
  - i_slv_valid is first sampled the cycle after the request; valid coincident with i_rd_req is ignored.
  - If the selected slave's valid is high: o_data <= that slave's slice, o_valid=1, o_err=0 on the next cycle; go to RESP.
  - Otherwise the counter decrements. When it would reach 0 with no valid: o_data=ERR_DATA, o_valid=1, o_err=1 next cycle; go to RESP.
  - Valid on the final counter cycle wins over timeout.
  - Unselected slave valids and data are ignored.
- RESP: lasts one cycle (o_valid high), then IDLE. o_busy is high in WAIT and RESP.
- Response latency: selected valid at cycle t gives o_valid at t+1. Best case is 2 cycles from request.
- i_rd_req in WAIT or RESP is discarded: o_req_drop pulses the next cycle and the outstanding transaction is unaffected.
- o_data holds its last value between responses.
- o_valid, o_err, o_req_drop and o_collision are single-cycle pulses.
- Counter width is $clog2(TIMEOUT_CYC+1). The counter never wraps.
- Slice selection is a mask-and-OR over the latched one-hot select, with no priority logic.

Optional Feature:
- Macro: RD_COLLISION_DET_EN.
- Defined:
  - In WAIT, any cycle with more than one bit of i_slv_valid high pulses o_collision the next cycle.
  - Response data still comes from the selected slave only.
  - o_collision pulses independently of o_valid.
- Undefined: o_collision is tied 0 and no popcount logic is synthesised.

Decomposition:
- Package rd_mux_pkg holds:
  - state enum {IDLE, WAIT, RESP};
  - default ERR_DATA constant;
  - function is_onehot();
  - function popcount_gt1().
- One combinational sub-module, rd_onehot_slice_sel (mask-and-OR of NUM_SLV slices by a one-hot select), is natural and reusable.
- The top level holds the FSM, counter and output registers.

Test Plan (NUM_SLV=4, DATA_W=8, TIMEOUT_CYC=8, ERR_DATA=8'hEE):
- Request with i_sel=4'b0100; slave 2 valid with 8'hA5 three cycles later -> o_valid=1, o_err=0, o_data=8'hA5 one cycle after that valid; o_busy falls after RESP.
- Request with i_sel=4'b0100 and no valid ever -> after 8 WAIT cycles o_valid=1, o_err=1, o_data=8'hEE; slave valid on the 8th cycle instead returns the real data.
- Request with i_sel=4'b0110, then with i_sel=4'b0000 -> each gives o_valid=1, o_err=1, o_data=8'hEE on the next cycle, with no WAIT.
- Second i_rd_req during WAIT -> o_req_drop pulse; the first request completes with the correct data; exactly one o_valid.
- In WAIT, slave 1 valid with 8'h3C and slave 2 (selected) valid with 8'h5A in the same cycle -> o_data=8'h5A; o_collision=1 only with RD_COLLISION_DET_EN, else 0.
- Assert i_rst mid-WAIT, between clock edges -> all outputs 0 immediately, no response after release; the next request with i_sel=4'b0001 and data 8'h11 completes normally.
